// File: rtl/decode_ctrl_pkg.sv
// Shared decode-stage definitions: opcodes, immediate/result/ALU encodings, control word layout.
// Pure declarations; no timing, no backpressure.
package decode_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_ADDI = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_NONE = 3'b111
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        result_src_t result_src;
        alu_op_t     alu_op;
    } ctrl_t;

    // Everything the execute stage needs from one decoded instruction.
    typedef struct packed {
        ctrl_t       ctrl;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_word_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/decode_ctrl_main.sv
// Main opcode decoder: opcode -> execute control word, immediate format, illegal flag.
// Purely combinational, zero latency; no backpressure.
module main_decoder
    import decode_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output imm_src_t   imm_src,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        imm_src = IMM_NONE;
        illegal = 1'b0;
        unique case (op)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                imm_src         = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                imm_src         = IMM_S;
            end
            OP_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_FUNCT;
                imm_src         = IMM_NONE;
            end
            OP_IALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_FUNCT;
                imm_src         = IMM_I;
            end
            OP_BRANCH: begin
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                imm_src         = IMM_B;
            end
            OP_JAL: begin
                // Target comes from the PC adder, so ALU operand select is irrelevant.
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_I;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                imm_src         = IMM_U;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: IF/ID and ID/EX pipeline registers, opcode decode, load-use and branch hazard control.
// Latency: InstrF -> InstrD 1 cycle, control word -> E outputs 2 cycles.
// Backpressure: load-use stalls F/D for one cycle with an E bubble; taken branch/jump bubbles D and E.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ADDI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic        PCSrcE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [2:0]  ImmSrcD,
    output logic        IllegalD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        BranchE,
    output logic        JumpE,
    output logic [1:0]  ResultSrcE,
    output logic [1:0]  ALUOpE,
    output logic [2:0]  Funct3E,
    output logic        Funct7b5E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE
);

    ctrl_t    ctrl_d;
    imm_src_t imm_src_d;
    ex_word_t ex_d;
    ex_word_t ex_q;
    logic     lw_stall;
    logic     flush_d;

    main_decoder u_main_decoder (
        .op      (InstrD[6:0]),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (IllegalD)
    );

    assign ImmSrcD = imm_src_d;

    // A load in E whose destination is read by the instruction in D must wait one cycle.
    assign lw_stall = (ex_q.ctrl.result_src == RES_MEM) && (ex_q.rd != 5'd0) &&
                      ((rs1_of(InstrD) == ex_q.rd) || (rs2_of(InstrD) == ex_q.rd));

    // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
    assign flush_d = PCSrcE;
    assign StallF  = lw_stall & ~PCSrcE;
    assign StallD  = lw_stall & ~PCSrcE;
    assign FlushE  = lw_stall | PCSrcE;

    always_comb begin
        ex_d          = '0;
        ex_d.ctrl     = ctrl_d;
        ex_d.funct3   = InstrD[14:12];
        ex_d.funct7b5 = InstrD[30];
        ex_d.rs1      = rs1_of(InstrD);
        ex_d.rs2      = rs2_of(InstrD);
        ex_d.rd       = rd_of(InstrD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD <= NOP_INSTR;
            PCD    <= '0;
        end else if (flush_d) begin
            InstrD <= NOP_INSTR;
            PCD    <= '0;
        end else if (!StallD) begin
            InstrD <= InstrF;
            PCD    <= PCF;
        end
    end

    // Reset and flush both leave an all-zero bubble in E.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegWriteE  = ex_q.ctrl.reg_write;
    assign MemWriteE  = ex_q.ctrl.mem_write;
    assign ALUSrcE    = ex_q.ctrl.alu_src;
    assign BranchE    = ex_q.ctrl.branch;
    assign JumpE      = ex_q.ctrl.jump;
    assign ResultSrcE = ex_q.ctrl.result_src;
    assign ALUOpE     = ex_q.ctrl.alu_op;
    assign Funct3E    = ex_q.funct3;
    assign Funct7b5E  = ex_q.funct7b5;
    assign Rs1E       = ex_q.rs1;
    assign Rs2E       = ex_q.rs2;
    assign RdE        = ex_q.rd;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: directed vector table, hand sequences, and random stream against a reference model.
module tb_decode_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SW    = 32'h0051_2423; // sw   x5,8(x2)
    localparam logic [31:0] LW6   = 32'h0000_A303; // lw   x6,0(x1)
    localparam logic [31:0] ADD7  = 32'h0033_03B3; // add  x7,x6,x3
    localparam logic [31:0] ADDI8 = 32'h0010_0413; // addi x8,x0,1
    localparam logic [31:0] ADDI9 = 32'h0020_0493; // addi x9,x0,2
    localparam logic [31:0] ILL   = 32'h0000_007F;
    localparam logic [31:0] LW0   = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD00 = 32'h0000_03B3; // add  x7,x0,x0

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrF, PCF;
    logic        PCSrcE;
    logic [31:0] InstrD, PCD;
    logic [2:0]  ImmSrcD, Funct3E;
    logic        IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, Funct7b5E;
    logic [1:0]  ResultSrcE, ALUOpE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        StallF, StallD, FlushE;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    decode_ctrl #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(PCF), .PCSrcE(PCSrcE),
        .InstrD(InstrD), .PCD(PCD), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUOpE(ALUOpE),
        .Funct3E(Funct3E), .Funct7b5E(Funct7b5E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE)
    );

    // Reference model: decode table rows, pipeline contents as plain variables.
    typedef struct {
        bit       rw, mw, as, as_dc, br, jp, ill;
        bit [1:0] rs, aop;
        bit [2:0] imm;
    } dec_t;

    typedef struct {
        bit       rw, mw, as, as_dc, br, jp;
        bit [1:0] rs, aop;
        bit [2:0] f3;
        bit       f7;
        bit [4:0] rs1, rs2, rd;
    } ex_t;

    bit [31:0] m_instr = NOP;
    bit [31:0] m_pc    = 0;
    ex_t       m_e     = '{default: 0};

    function automatic dec_t row(bit rw, bit [2:0] imm, bit as, bit mw, bit [1:0] rs,
                                 bit br, bit jp, bit [1:0] aop, bit dc, bit ill);
        dec_t d;
        d.rw = rw; d.imm = imm; d.as = as; d.mw = mw; d.rs = rs;
        d.br = br; d.jp = jp; d.aop = aop; d.as_dc = dc; d.ill = ill;
        return d;
    endfunction

    function automatic dec_t dec(bit [6:0] op);
        case (op)
            7'b0000011: return row(1, 3'b000, 1, 0, 2'b01, 0, 0, 2'b00, 0, 0);
            7'b0100011: return row(0, 3'b001, 1, 1, 2'b00, 0, 0, 2'b00, 0, 0);
            7'b0110011: return row(1, 3'b111, 0, 0, 2'b00, 0, 0, 2'b10, 0, 0);
            7'b0010011: return row(1, 3'b000, 1, 0, 2'b00, 0, 0, 2'b10, 0, 0);
            7'b1100011: return row(0, 3'b010, 0, 0, 2'b00, 1, 0, 2'b01, 0, 0);
            7'b1101111: return row(1, 3'b011, 0, 0, 2'b10, 0, 1, 2'b00, 1, 0);
            7'b1100111: return row(1, 3'b000, 1, 0, 2'b10, 0, 1, 2'b00, 0, 0);
            7'b0110111,
            7'b0010111: return row(1, 3'b100, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0);
            default:    return row(0, 3'b111, 0, 0, 2'b00, 0, 0, 2'b00, 0, 1);
        endcase
    endfunction

    function automatic bit model_lw();
        return (m_e.rs == 2'b01) && (m_e.rd != 0) &&
               ((m_instr[19:15] == m_e.rd) || (m_instr[24:20] == m_e.rd));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        dec_t d  = dec(m_instr[6:0]);
        bit   lw = model_lw();
        bit   as_act;
        as_act = m_e.as_dc ? m_e.as : ALUSrcE;
        chk("m_instr_d", InstrD, m_instr);
        chk("m_pc_d", PCD, m_pc);
        chk("m_imm_src", {29'd0, ImmSrcD}, {29'd0, d.imm});
        chk("m_illegal", {31'd0, IllegalD}, {31'd0, d.ill});
        chk("m_ctrl_e", {23'd0, RegWriteE, MemWriteE, as_act, BranchE, JumpE, ResultSrcE, ALUOpE},
            {23'd0, m_e.rw, m_e.mw, m_e.as, m_e.br, m_e.jp, m_e.rs, m_e.aop});
        chk("m_fields_e", {13'd0, Funct3E, Funct7b5E, Rs1E, Rs2E, RdE},
            {13'd0, m_e.f3, m_e.f7, m_e.rs1, m_e.rs2, m_e.rd});
        chk("m_hazard", {29'd0, StallF, StallD, FlushE},
            {29'd0, lw & ~PCSrcE, lw & ~PCSrcE, lw | PCSrcE});
    endtask

    task automatic model_step();
        dec_t d  = dec(m_instr[6:0]);
        bit   lw = model_lw();
        if (reset) begin
            m_instr = NOP; m_pc = 0; m_e = '{default: 0};
        end else begin
            if (lw || PCSrcE) m_e = '{default: 0};
            else begin
                m_e.rw = d.rw; m_e.mw = d.mw; m_e.as = d.as; m_e.as_dc = d.as_dc;
                m_e.br = d.br; m_e.jp = d.jp; m_e.rs = d.rs; m_e.aop = d.aop;
                m_e.f3 = m_instr[14:12]; m_e.f7 = m_instr[30];
                m_e.rs1 = m_instr[19:15]; m_e.rs2 = m_instr[24:20]; m_e.rd = m_instr[11:7];
            end
            if (PCSrcE) begin
                m_instr = NOP; m_pc = 0;
            end else if (!lw) begin
                m_instr = InstrF; m_pc = PCF;
            end
        end
    endtask

    task automatic drive(input bit r, input bit [31:0] i, input bit [31:0] p, input bit s);
        @(negedge clk);
        reset = r; InstrF = i; PCF = p; PCSrcE = s;
        #1;
    endtask

    task automatic end_cycle();
        if (chk_en) model_check();
        @(posedge clk);
        model_step();
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] x = $urandom;
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        x[11:7]  = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0, 1: x[6:0] = 7'b0000011;
            2:    x[6:0] = 7'b0100011;
            3:    x[6:0] = 7'b0110011;
            4:    x[6:0] = 7'b0010011;
            5:    x[6:0] = 7'b1100011;
            6:    x[6:0] = 7'b1101111;
            7:    x[6:0] = 7'b1100111;
            8:    x[6:0] = 7'b0110111;
            9:    x[6:0] = 7'b0010111;
            default: ;
        endcase
        return x;
    endfunction

    typedef struct {
        bit [31:0] instr_f, pc_f;
        bit        pcsrc;
        bit [31:0] instr_d, pc_d;
        bit [2:0]  imm;
        bit        ill, stall, flush, rw, mw, as;
        bit [1:0]  rs;
        bit [4:0]  rd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{SW,    32'h100, 0, NOP,   32'h000, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0};
        vecs[1]  = '{LW6,   32'h104, 0, SW,    32'h100, 3'b001, 0, 0, 0, 1, 0, 1, 2'b00, 5'd0};
        vecs[2]  = '{ADD7,  32'h108, 0, LW6,   32'h104, 3'b000, 0, 0, 0, 0, 1, 1, 2'b00, 5'd8};
        vecs[3]  = '{ADDI8, 32'h10C, 0, ADD7,  32'h108, 3'b111, 0, 1, 1, 1, 0, 1, 2'b01, 5'd6};
        vecs[4]  = '{ADDI8, 32'h10C, 0, ADD7,  32'h108, 3'b111, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0};
        vecs[5]  = '{ADDI9, 32'h110, 1, ADDI8, 32'h10C, 3'b000, 0, 0, 1, 1, 0, 0, 2'b00, 5'd7};
        vecs[6]  = '{ILL,   32'h200, 0, NOP,   32'h000, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0};
        vecs[7]  = '{LW6,   32'h204, 0, ILL,   32'h200, 3'b111, 1, 0, 0, 1, 0, 1, 2'b00, 5'd0};
        vecs[8]  = '{ADD7,  32'h208, 0, LW6,   32'h204, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0};
        vecs[9]  = '{ADDI8, 32'h20C, 1, ADD7,  32'h208, 3'b111, 0, 0, 1, 1, 0, 1, 2'b01, 5'd6};
        vecs[10] = '{ADDI8, 32'h300, 0, NOP,   32'h000, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0};

        reset = 1; InstrF = 0; PCF = 0; PCSrcE = 0;
        drive(1, NOP, 0, 0); end_cycle();
        drive(1, NOP, 0, 0); end_cycle();
        chk_en = 1;

        foreach (vecs[k]) begin
            drive(0, vecs[k].instr_f, vecs[k].pc_f, vecs[k].pcsrc);
            chk($sformatf("v%0d_instr_d", k), InstrD, vecs[k].instr_d);
            chk($sformatf("v%0d_pc_d", k), PCD, vecs[k].pc_d);
            chk($sformatf("v%0d_imm_src", k), {29'd0, ImmSrcD}, {29'd0, vecs[k].imm});
            chk($sformatf("v%0d_illegal", k), {31'd0, IllegalD}, {31'd0, vecs[k].ill});
            chk($sformatf("v%0d_stall_f", k), {31'd0, StallF}, {31'd0, vecs[k].stall});
            chk($sformatf("v%0d_stall_d", k), {31'd0, StallD}, {31'd0, vecs[k].stall});
            chk($sformatf("v%0d_flush_e", k), {31'd0, FlushE}, {31'd0, vecs[k].flush});
            chk($sformatf("v%0d_regwrite_e", k), {31'd0, RegWriteE}, {31'd0, vecs[k].rw});
            chk($sformatf("v%0d_memwrite_e", k), {31'd0, MemWriteE}, {31'd0, vecs[k].mw});
            chk($sformatf("v%0d_alusrc_e", k), {31'd0, ALUSrcE}, {31'd0, vecs[k].as});
            chk($sformatf("v%0d_resultsrc_e", k), {30'd0, ResultSrcE}, {30'd0, vecs[k].rs});
            chk($sformatf("v%0d_rd_e", k), {27'd0, RdE}, {27'd0, vecs[k].rd});
            end_cycle();
        end

        // Reset arriving while a load-use stall is active.
        drive(0, LW6, 32'h304, 0);  end_cycle();
        drive(0, ADD7, 32'h308, 0); end_cycle();
        drive(1, ADD7, 32'h30C, 0);
        chk("rst_stall_pre", {31'd0, StallF}, 32'd1);
        end_cycle();
        drive(0, LW0, 32'h400, 0);
        chk("rst_stall_instr_d", InstrD, NOP);
        chk("rst_stall_pc_d", PCD, 32'd0);
        chk("rst_stall_rd_e", {27'd0, RdE}, 32'd0);
        chk("rst_stall_resultsrc_e", {30'd0, ResultSrcE}, 32'd0);
        chk("rst_stall_post", {31'd0, StallF}, 32'd0);
        end_cycle();

        // A load to x0 never stalls its consumer.
        drive(0, ADD00, 32'h404, 0); end_cycle();
        drive(0, NOP, 32'h408, 0);
        chk("x0_load_in_e", {30'd0, ResultSrcE}, 32'd1);
        chk("x0_no_stall", {31'd0, StallD}, 32'd0);
        chk("x0_no_flush", {31'd0, FlushE}, 32'd0);
        end_cycle();

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 49) == 0, rand_instr(), $urandom, $urandom_range(0, 6) == 0);
            end_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
